// File: rtl/job_dispatcher.sv
// Job dispatcher: queues job IDs in a 4-entry FIFO, launches them one at a time on a
// worker, watches for completion or timeout and reports each result over a handshake.
module job_dispatcher #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_id,
    output logic       req_ready,
    output logic       start,
    input  logic       worker_busy,
    input  logic       worker_done,
    output logic       cmp_valid,
    output logic [3:0] cmp_id,
    output logic       cmp_timeout,
    input  logic       cmp_ready,
    output logic [2:0] fifo_count,
    output logic [7:0] jobs_done,
    output logic [7:0] timeout_count
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] REPORT    = 2'd3;

    localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);
    localparam logic [7:0] LAST_TICK  = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state_reg, state_next;
    logic [1:0] wr_ptr_reg, wr_ptr_next;
    logic [1:0] rd_ptr_reg, rd_ptr_next;
    logic [2:0] count_reg, count_next;
    logic [7:0] timer_reg, timer_next;
    logic [3:0] cur_id_reg;
    logic       timeout_reg, timeout_next;
    logic [7:0] jobs_reg, jobs_next;
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;

    logic [3:0] fifo_mem [0:3];
    logic       push;
    logic       pop;

    assign req_ready = (count_reg != FULL_COUNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != 3'd0) && !worker_busy;

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        timeout_next = timeout_reg;
        jobs_next    = jobs_reg;
        tmo_cnt_next = tmo_cnt_reg;
        wr_ptr_next  = push ? wr_ptr_reg + 2'd1 : wr_ptr_reg;
        rd_ptr_next  = pop ? rd_ptr_reg + 2'd1 : rd_ptr_reg;

        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase

        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_next = 8'd0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_next = timer_reg + 8'd1;
                // A completion arriving on the expiry cycle still counts as success.
                if (worker_done) begin
                    timeout_next = 1'b0;
                    state_next   = REPORT;
                end else if (timer_reg == LAST_TICK) begin
                    timeout_next = 1'b1;
                    state_next   = REPORT;
                end
            end
            REPORT: begin
                if (cmp_ready) begin
                    jobs_next = jobs_reg + 8'd1;
                    if (timeout_reg && (tmo_cnt_reg != 8'hFF)) begin
                        tmo_cnt_next = tmo_cnt_reg + 8'd1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= 2'd0;
            rd_ptr_reg  <= 2'd0;
            count_reg   <= 3'd0;
            timer_reg   <= 8'd0;
            cur_id_reg  <= 4'd0;
            timeout_reg <= 1'b0;
            jobs_reg    <= 8'd0;
            tmo_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            timer_reg   <= timer_next;
            timeout_reg <= timeout_next;
            jobs_reg    <= jobs_next;
            tmo_cnt_reg <= tmo_cnt_next;
            if (pop) begin
                cur_id_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    // Queue storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= req_id;
        end
    end

    assign start         = (state_reg == LAUNCH);
    assign cmp_valid     = (state_reg == REPORT);
    assign cmp_id        = cur_id_reg;
    assign cmp_timeout   = timeout_reg;
    assign fifo_count    = count_reg;
    assign jobs_done     = jobs_reg;
    assign timeout_count = tmo_cnt_reg;

endmodule

// File: tb/tb_job_dispatcher.sv
// Scoreboard bench for job_dispatcher: a behavioural worker decides each job's outcome,
// expected completion records are queued at launch and matched by a negedge monitor.
module tb_job_dispatcher;

    localparam int T = 16;

    typedef struct {
        logic [3:0] id;
        logic       to;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_id = 4'd0;
    logic       req_ready;
    logic       start;
    logic       worker_busy;
    logic       worker_done;
    logic       cmp_valid;
    logic [3:0] cmp_id;
    logic       cmp_timeout;
    logic       cmp_ready = 1'b1;
    logic [2:0] fifo_count;
    logic [7:0] jobs_done;
    logic [7:0] timeout_count;

    logic w_busy = 1'b0;
    logic w_done = 1'b0;
    logic force_busy = 1'b0;
    int   next_delay = 0;

    assign worker_busy = w_busy | force_busy;
    assign worker_done = w_done;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [3:0] acc_q [$];
    rec_t       exp_q [$];
    logic [7:0] model_jobs = 8'd0;
    logic [7:0] model_to = 8'd0;

    job_dispatcher #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_id        (req_id),
        .req_ready     (req_ready),
        .start         (start),
        .worker_busy   (worker_busy),
        .worker_done   (worker_done),
        .cmp_valid     (cmp_valid),
        .cmp_id        (cmp_id),
        .cmp_timeout   (cmp_timeout),
        .cmp_ready     (cmp_ready),
        .fifo_count    (fifo_count),
        .jobs_done     (jobs_done),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, got no event, expected one (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits negedge by negedge for start (want_start=1) or cmp_valid; n counts negedges.
    task automatic wait_neg(input bit want_start, input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (want_start ? start : cmp_valid) break;
            if (n >= 200) begin
                bound_fail(name);
                break;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (t < 3000 && !(exp_q.size() == 0 && acc_q.size() == 0 && !w_busy &&
                             !cmp_valid && !start && fifo_count == 3'd0)) begin
            step(1);
            t++;
        end
        if (t >= 3000) bound_fail("drain");
        step(2);
    endtask

    // One job from an idle dispatcher: checks launch latency, report latency and outcome.
    task automatic run_one(input logic [3:0] id, input int delay);
        int n;
        req_valid  = 1'b1;
        req_id     = id;
        next_delay = delay;
        step(1);
        req_valid = 1'b0;
        wait_neg(1'b1, "run_start", n);
        check("launch_latency", n, 2);
        step(1);
        next_delay = 0;
        wait_neg(1'b0, "run_cmp", n);
        check("report_latency", n, ((delay > T) ? T : delay) + 1);
        check("run_cmp_id", cmp_id, id);
        check("run_cmp_timeout", cmp_timeout, (delay > T) ? 1 : 0);
        step(1);
        drain();
    endtask

    // Behavioural worker: busy from the cycle after start until it signals done j cycles later.
    initial begin : worker
        int   j;
        rec_t r;
        forever begin
            @(negedge clk);
            if (reset && start) begin
                j = (next_delay != 0) ? next_delay : int'($urandom_range(1, T + 4));
                if (acc_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL launch_without_job: start seen, expected no start (cycle %0d)", cyc);
                end else begin
                    r.id = acc_q.pop_front();
                    r.to = (j > T);
                    exp_q.push_back(r);
                end
                for (int k = 1; k <= j; k++) begin
                    @(posedge clk);
                    #1;
                    w_busy = 1'b1;
                    w_done = (k == j);
                end
                @(posedge clk);
                #1;
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit         seen_rst;
        bit         prev_rst_low;
        bit         hold;
        logic [3:0] hold_id;
        logic       hold_to;
        int         last_start;
        rec_t       e;
        seen_rst = 0;
        prev_rst_low = 0;
        hold = 0;
        hold_id = 4'd0;
        hold_to = 1'b0;
        last_start = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (seen_rst) begin
                if (prev_rst_low) begin
                    check("rst_start", start, 0);
                    check("rst_cmp_valid", cmp_valid, 0);
                    check("rst_cmp_id", cmp_id, 0);
                    check("rst_cmp_timeout", cmp_timeout, 0);
                    check("rst_fifo_count", fifo_count, 0);
                    check("rst_req_ready", req_ready, 1);
                    check("rst_jobs_done", jobs_done, 0);
                    check("rst_timeout_count", timeout_count, 0);
                end
                check("ready_vs_count", req_ready, (fifo_count != 3'd4) ? 1 : 0);
                check("count_range", (fifo_count <= 3'd4) ? 1 : 0, 1);
                check("jobs_done", jobs_done, model_jobs);
                check("timeout_count", timeout_count, model_to);
                check("start_cmp_exclusive", start & cmp_valid, 0);
                if (hold && !prev_rst_low) begin
                    check("hold_valid", cmp_valid, 1);
                    check("hold_id", cmp_id, hold_id);
                    check("hold_timeout", cmp_timeout, hold_to);
                end
                if (start) begin
                    if (last_start >= 0) check("start_spacing", ((cyc - last_start) >= 4) ? 1 : 0, 1);
                    last_start = cyc;
                end
            end
            hold = 0;
            if (!reset) begin
                seen_rst = 1;
                acc_q.delete();
                exp_q.delete();
                model_jobs = 8'd0;
                model_to = 8'd0;
            end else if (seen_rst) begin
                if (req_valid && req_ready) acc_q.push_back(req_id);
                if (cmp_valid) begin
                    if (cmp_ready) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_cmp: got id 0x%0h, expected no completion (cycle %0d)", cmp_id, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("cmp_id", cmp_id, e.id);
                            check("cmp_timeout", cmp_timeout, e.to);
                            model_jobs = model_jobs + 8'd1;
                            if (e.to && model_to != 8'hFF) model_to = model_to + 8'd1;
                        end
                    end else begin
                        hold = 1;
                        hold_id = cmp_id;
                        hold_to = cmp_timeout;
                    end
                end
            end
            prev_rst_low = !reset;
        end
    end

    initial begin : watchdog
        #500000;
        bound_fail("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "simulation did not complete");
    end

    initial begin : driver
        int n;
        step(3);
        reset = 1'b1;
        step(1);
        drain();

        // Single job: push at cycle 0, start at 2, done at 4, report at 5.
        req_valid = 1'b1;
        req_id = 4'd5;
        next_delay = 2;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("single_start", start, (c == 2) ? 1 : 0);
            check("single_cmp_valid", cmp_valid, (c == 5) ? 1 : 0);
            if (c == 5) begin
                check("single_cmp_id", cmp_id, 5);
                check("single_cmp_timeout", cmp_timeout, 0);
            end
            if (c == 6) check("single_jobs_done", jobs_done, 1);
            step(1);
            if (c == 0) req_valid = 1'b0;
            if (c == 2) next_delay = 0;
        end
        drain();

        // Timeout: worker never completes within the window.
        run_one(4'd3, T + 5);
        @(negedge clk);
        check("timeout_count_after", timeout_count, 1);
        check("jobs_after_timeout", jobs_done, 2);
        step(1);

        // Done/expiry tie and its neighbours.
        run_one(4'd7, T);
        run_one(4'd8, T + 1);
        run_one(4'd6, 1);

        // FIFO full with the worker held busy.
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            req_valid = 1'b1;
            req_id = 4'(i);
            step(1);
        end
        @(negedge clk);
        check("full_count", fifo_count, 4);
        check("full_ready", req_ready, 0);
        check("full_accepted", acc_q.size(), 4);
        step(2);
        @(negedge clk);
        check("full_count_hold", fifo_count, 4);
        step(1);
        req_valid = 1'b0;
        force_busy = 1'b0;
        drain();

        // Backpressure: 10 stalled REPORT cycles while new jobs are pushed.
        cmp_ready = 1'b0;
        req_valid = 1'b1;
        req_id = 4'd9;
        next_delay = 3;
        step(1);
        req_valid = 1'b0;
        wait_neg(1'b1, "bp_start", n);
        step(1);
        next_delay = 0;
        wait_neg(1'b0, "bp_cmp", n);
        for (int k = 0; k < 10; k++) begin
            step(1);
            req_valid = (k < 3);
            req_id = 4'(10 + k);
            @(negedge clk);
            check("bp_valid", cmp_valid, 1);
            check("bp_id", cmp_id, 9);
            check("bp_start", start, 0);
        end
        check("bp_fifo_count", fifo_count, 3);
        step(1);
        req_valid = 1'b0;
        cmp_ready = 1'b1;
        drain();

        // Reset in WAIT_DONE with two jobs queued.
        req_valid = 1'b1;
        req_id = 4'd2;
        next_delay = T + 10;
        step(1);
        req_valid = 1'b0;
        wait_neg(1'b1, "rstjob_start", n);
        step(1);
        next_delay = 0;
        req_valid = 1'b1;
        req_id = 4'd11;
        step(1);
        req_id = 4'd12;
        step(1);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstjob_queued", fifo_count, 2);
        check("rstjob_waiting", cmp_valid, 0);
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        @(negedge clk);
        check("rstjob_fifo_count", fifo_count, 0);
        check("rstjob_cmp_valid", cmp_valid, 0);
        check("rstjob_start", start, 0);
        step(1);
        drain();
        run_one(4'd4, 1);

        // Randomized traffic with random completion timing and consumer stalls.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 9) < 4);
            req_id = 4'($urandom_range(0, 15));
            cmp_ready = ($urandom_range(0, 9) < 7);
            step(1);
        end
        req_valid = 1'b0;
        cmp_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
